// File: rtl/tag_retire_queue.sv
// tag_retire_queue: in-order tag return path for the dispatcher's tag free list.
// Allocated tags are queued in program order, marked done when they show up
// on the CDB, and handed back to the free-list FIFO strictly in allocation
// order, at most one per cycle, while the FIFO is not full.
module tag_retire_queue #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    input  logic [DATA_WIDTH-1:0] alloc_tag,
    input  logic                  cdb_tag_valid,
    input  logic [DATA_WIDTH-1:0] cdb_tag,
    input  logic                  tf_full,
    output logic                  ret_tag_valid,
    output logic [DATA_WIDTH-1:0] ret_tag,
    output logic                  full_rq,
    output logic                  empty_rq,
    output logic [DATA_WIDTH:0]   count_rq,
    output logic                  err_rq
);

    localparam int PW = DATA_WIDTH + 1;

    // Order ring; contents need no reset because pointers define validity.
    logic [DATA_WIDTH-1:0] q [DEPTH];

    // Pointers carry an extra wrap bit to tell full from empty.
    logic [PW-1:0] rp;
    logic [PW-1:0] wp;

    // Per-tag tracking bits, indexed by tag value.
    logic [DEPTH-1:0] inflight;
    logic [DEPTH-1:0] done;
    logic [DEPTH-1:0] inflight_next;
    logic [DEPTH-1:0] done_next;

    logic                  err;
    logic [DATA_WIDTH-1:0] head_tag;
    logic                  alloc_ok;
    logic                  cdb_ok;
    logic                  retire;
    logic                  err_event;

    // Occupancy flags come straight from the registered pointers.
    assign full_rq  = (rp[DATA_WIDTH-1:0] == wp[DATA_WIDTH-1:0]) &&
                      (rp[DATA_WIDTH] != wp[DATA_WIDTH]);
    assign empty_rq = (rp == wp);
    assign count_rq = wp - rp;
    assign err_rq   = err;

    // The head is read asynchronously so a done head retires on the very next edge.
    assign head_tag = q[rp[DATA_WIDTH-1:0]];

    // All acceptance decisions use registered state only; a tag being retired
    // this cycle still looks in-flight and done, so reusing it is rejected.
    assign alloc_ok  = alloc_valid && !full_rq && !inflight[alloc_tag];
    assign cdb_ok    = cdb_tag_valid && inflight[cdb_tag] && !done[cdb_tag];
    assign retire    = !empty_rq && done[head_tag] && !tf_full;
    assign err_event = (alloc_valid && !alloc_ok) || (cdb_tag_valid && !cdb_ok);

    // Per-tag next-state: retire clears, allocate arms, CDB marks done.
    // Allocate and CDB on the same tag are mutually exclusive (inflight gate),
    // and neither can hit the retiring tag, so the priority here never matters
    // for legal or illegal traffic beyond making the clear win.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag
            logic hit_alloc;
            logic hit_cdb;
            logic hit_ret;

            assign hit_alloc = alloc_ok && (alloc_tag == DATA_WIDTH'(gi));
            assign hit_cdb   = cdb_ok   && (cdb_tag   == DATA_WIDTH'(gi));
            assign hit_ret   = retire   && (head_tag  == DATA_WIDTH'(gi));

            assign inflight_next[gi] = hit_ret ? 1'b0 : (inflight[gi] | hit_alloc);
            assign done_next[gi]     = (hit_ret || hit_alloc) ? 1'b0 : (done[gi] | hit_cdb);
        end
    endgenerate

    // Ring write on every accepted allocate.
    always_ff @(posedge clk) begin
        if (alloc_ok) begin
            q[wp[DATA_WIDTH-1:0]] <= alloc_tag;
        end
    end

    // Pointer advance; wraps naturally at 2**(DATA_WIDTH+1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp <= '0;
            wp <= '0;
        end else begin
            if (alloc_ok) begin
                wp <= wp + PW'(1);
            end
            if (retire) begin
                rp <= rp + PW'(1);
            end
        end
    end

    // Per-tag tracking vectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            done     <= '0;
        end else begin
            inflight <= inflight_next;
            done     <= done_next;
        end
    end

    // Registered return pulse; the tag holds its value between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_tag_valid <= 1'b0;
            ret_tag       <= '0;
        end else begin
            ret_tag_valid <= retire;
            if (retire) begin
                ret_tag <= head_tag;
            end
        end
    end

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_event) begin
            err <= 1'b1;
        end
    end

endmodule

// File: doc/tag_retire_queue.md
# tag_retire_queue

In-order tag return queue for the dispatcher's tag free list. It records each tag the dispatcher allocates, in program order, and marks tags complete as they appear on the CDB. It then hands completed tags back to the tag free-list FIFO strictly in allocation order, one per cycle. It is the return-path counterpart of the free list: the free list issues tags, and this block recycles them.

## Interface

**Parameters**
- `DEPTH`, default 64: queue entries; equals the number of tags.
- `DATA_WIDTH`, default 6: tag width; `2**DATA_WIDTH == DEPTH`.

**Ports**
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `alloc_valid`, input, 1: the dispatcher took a tag from the free list this cycle.
- `alloc_tag`, input, DATA_WIDTH: the allocated tag.
- `cdb_tag_valid`, input, 1: a CDB broadcast is present.
- `cdb_tag`, input, DATA_WIDTH: the completing tag.
- `tf_full`, input, 1: the free-list FIFO is full; the return path is stalled.
- `ret_tag_valid`, output, 1: registered one-cycle pulse; write `ret_tag` into the free list.
- `ret_tag`, output, DATA_WIDTH: registered returned tag.
- `full_rq`, output, 1: queue holds DEPTH entries.
- `empty_rq`, output, 1: queue holds 0 entries.
- `count_rq`, output, DATA_WIDTH+1: current occupancy, 0..DEPTH.
- `err_rq`, output, 1: sticky protocol-error flag.

## Operation

**State**
- Order ring `q[DEPTH]` of tags.
- Read pointer `rp` and write pointer `wp`, each DATA_WIDTH+1 bits; the MSB is a wrap bit.
- Per-tag bit vectors `inflight[DEPTH]` and `done[DEPTH]`.
- `full_rq` = low bits equal and MSBs differ. `empty_rq` = `rp == wp`. `count_rq` = `wp - rp`, modulo 2^(DATA_WIDTH+1).

**Allocate**
- Accepted when `alloc_valid`, not `full_rq`, and not `inflight[alloc_tag]`.
- Effect: `q[wp] <= alloc_tag`, `wp++`, `inflight[alloc_tag] <= 1`, `done[alloc_tag] <= 0`.

**Complete**
- Accepted when `cdb_tag_valid`, `inflight[cdb_tag]`, and not `done[cdb_tag]`.
- Effect: `done[cdb_tag] <= 1`.

**Retire**
- Condition: not `empty_rq`, `done[q[rp]]`, and not `tf_full`. At most one retire per cycle.
- Effect: `ret_tag <= q[rp]`, `ret_tag_valid <= 1`, `rp++`, `inflight` and `done` for that tag cleared.
- Otherwise `ret_tag_valid <= 0` and `ret_tag` holds its value.

**Simultaneous events**
- Allocate and retire in the same cycle: both take effect; count is unchanged.
- Allocate when full is rejected even if a retire happens in the same cycle (no same-cycle slot reuse).
- CDB for the tag being retired in the same cycle cannot occur legally. It is flagged as an error because `done` is already set.
- Allocate of the tag being retired in the same cycle: rejected, because `inflight` is evaluated from registered state. This is an error.

**Errors**
- The following are ignored, with no state change, and set `err_rq`:
  - allocate while full;
  - allocate of an in-flight tag;
  - CDB for a tag that is not in flight or is already done.
- `err_rq` clears only on reset.

**Pointer wrap**
- Pointers wrap naturally at 2^(DATA_WIDTH+1).
- The ring index is the low DATA_WIDTH bits.

## Timing

**Reset (`rst_n` low, asynchronous)**
- `rp = wp = 0`; all `inflight` and `done` bits 0.
- `ret_tag_valid = 0`, `ret_tag = 0`, `empty_rq = 1`, `full_rq = 0`, `count_rq = 0`, `err_rq = 0`.
- Ring contents are don't-care.
- Reset asserted mid-operation discards all in-flight tags immediately. The free list is reset in the same event.

**Latency**
- Allocate at edge N: `count_rq` and `empty_rq` reflect it after edge N.
- CDB at edge N sets `done` at N. If that tag is at the head and `tf_full` is low during cycle N+1, `ret_tag_valid` goes high after edge N+1: two cycles from CDB to return.
- A head entry that is already done retires on the next edge. A run of completed entries retires back-to-back, one per cycle.

**Stall**
- `tf_full` high in a cycle blocks the retire at that edge.
- The head and its done state are held; retire resumes on the first edge with `tf_full` low.

**Flags**
- `full_rq`, `empty_rq` and `count_rq` are derived combinationally from the registered pointers.

## Test plan

1. **Reset, then in-order retire:** reset → all outputs at reset values. Allocate tags 5, 9, 2; CDB 5, 9, 2 → `ret_tag` pulses 5, 9, 2 on consecutive cycles, each 2 cycles after its CDB; `count_rq` 3→0.
2. **Out-of-order completion:** allocate 5, 9, 2; CDB 2, 9, then 5 → no return until 5 completes, then 5, 9, 2 back-to-back on 3 consecutive cycles.
3. **Full and wrap:** allocate all 64 tags 0..63 → `full_rq = 1`. A further allocate sets `err_rq` with `count_rq` staying 64. Complete all, retire 64, then allocate 10 more → pointer wrap is correct and order is preserved.
4. **Backpressure:** head done with `tf_full` held high for 4 cycles → `ret_tag_valid` stays 0. On the first cycle with `tf_full` low, one pulse with the correct tag; no duplicate and no loss.
5. **Errors:**
   - CDB for tag 7 not in flight → `err_rq = 1`, state unchanged.
   - Duplicate CDB for an already-done tag → `err_rq` set, single return only.
   - Allocate of an in-flight tag → `err_rq` set, `count_rq` unchanged.
6. **Simultaneous events and reset:**
   - Allocate and retire in the same cycle at `count_rq = 3` → count stays 3.
   - `rst_n` pulsed low mid-stream with 10 entries in flight → immediate `empty_rq = 1` and `ret_tag_valid = 0`; after reset, a fresh allocate of a previously in-flight tag is accepted without error.
